vec_sq_sum: RTL and testbench

Sequential sum-of-squares front end for the 2D vector-length datapath. Accepts a signed (x, y) pair over a valid/ready handshake and computes x² + y² with a single shift-add squaring core over 2·W cycles. Presents the result as a held level on `xin`/`data_rdy`, the operand side of `sqrt32`. The pair forms the complete |v| = sqrt(x² + y²) pipeline.

---
 rtl/vec_len_pkg.sv | 6 +
 rtl/seq_sq_acc.sv | 35 +++
 rtl/vec_sq_sum.sv | 89 ++++++++
 tb/tb_vec_sq_sum.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vec_len_pkg.sv
// vec_len_pkg: shared widths and FSM state type for the vector-length datapath
package vec_len_pkg;
    localparam int VEC_W = 16;
    localparam int SQ_W  = 2 * VEC_W;
    typedef enum logic [1:0] {IDLE, SQ_X, SQ_Y, DONE} state_t;
endpackage

// File: rtl/seq_sq_acc.sv
// seq_sq_acc: one-bit-per-cycle shift-add squaring step into an external accumulator
module seq_sq_acc
    import vec_len_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           load_i,
    input  logic           step_i,
    input  logic [W-1:0]   mag_i,
    input  logic [2*W-1:0] acc_i,
    output logic [2*W-1:0] acc_o,
    output logic           last_o
);
    localparam int CW = $clog2(W);

    logic [W-1:0]  mag_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mag_q <= '0;
            cnt_q <= '0;
        end else if (load_i) begin
            mag_q <= mag_i;
            cnt_q <= '0;
        end else if (step_i) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign acc_o  = mag_q[cnt_q] ? acc_i + ({{W{1'b0}}, mag_q} << cnt_q) : acc_i;
    assign last_o = cnt_q == CW'(W - 1);
endmodule

// File: rtl/vec_sq_sum.sv
// vec_sq_sum: sequential x^2 + y^2 front end feeding sqrt32, one shared squaring core
module vec_sq_sum
    import vec_len_pkg::*;
#(
    parameter int W = VEC_W
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   x_in,
    input  logic [W-1:0]   y_in,
    output logic           data_rdy,
    output logic [2*W-1:0] xin,
    input  logic           out_ack
);
    state_t         state_q, state_d;
    logic [2*W-1:0] acc_q, acc_d, xin_q, xin_d, acc_nx;
    logic [W-1:0]   mag_y_q, mag_y_d, mag_x, mag_y, ld_mag;
    logic           rdy_q, load, step, last, accept;

    // Two's complement negate in W bits maps -2^(W-1) onto 2^(W-1) unsigned
    assign mag_x    = x_in[W-1] ? W'(-x_in) : x_in;
    assign mag_y    = y_in[W-1] ? W'(-y_in) : y_in;
    assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ack);
    assign accept   = in_valid & in_ready;
    assign data_rdy = rdy_q;
    assign xin      = xin_q;

    seq_sq_acc #(.W(W)) u_sq (
        .clk    (clk),
        .rstn   (rstn),
        .load_i (load),
        .step_i (step),
        .mag_i  (ld_mag),
        .acc_i  (acc_q),
        .acc_o  (acc_nx),
        .last_o (last)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mag_y_d = mag_y_q;
        xin_d   = xin_q;
        load    = 1'b0;
        step    = 1'b0;
        ld_mag  = mag_x;
        if (accept) begin
            state_d = SQ_X;
            acc_d   = '0;
            mag_y_d = mag_y;
            load    = 1'b1;
        end else if (state_q == SQ_X) begin
            step  = 1'b1;
            acc_d = acc_nx;
            if (last) begin
                state_d = SQ_Y;
                load    = 1'b1;
                ld_mag  = mag_y_q;
            end
        end else if (state_q == SQ_Y) begin
            step  = 1'b1;
            acc_d = acc_nx;
            if (last) begin
                state_d = DONE;
                xin_d   = acc_nx;
            end
        end else if (state_q == DONE && out_ack) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mag_y_q <= '0;
            xin_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mag_y_q <= mag_y_d;
            xin_q   <= xin_d;
            rdy_q   <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_vec_sq_sum.sv
// tb_vec_sq_sum: randomized and directed checks of vec_sq_sum against an arithmetic model
module tb_vec_sq_sum;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        in_valid = 1'b0, out_ack = 1'b0;
    logic [15:0] x_in = '0, y_in = '0;
    logic        in_ready, data_rdy;
    logic [31:0] xin;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    vec_sq_sum dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .y_in     (y_in),
        .data_rdy (data_rdy),
        .xin      (xin),
        .out_ack  (out_ack)
    );

    function automatic logic [31:0] sq_sum(int x, int y);
        return 32'(longint'(x) * x + longint'(y) * y);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(int x, int y);
        int n = 0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("start_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        x_in     = 16'(x);
        y_in     = 16'(y);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_done(string tag, logic [31:0] exp, int lat);
        int n = 0;
        while (!data_rdy && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(lat));
        check(tag, xin, exp);
    endtask

    task automatic ack();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
        check("ack_rdy_drop", 32'(data_rdy), 32'd0);
        check("ack_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic job(string tag, int x, int y);
        start_job(x, y);
        wait_done(tag, sq_sum(x, y), 32);
        ack();
    endtask

    initial begin
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data_rdy", 32'(data_rdy), 32'd0);
        check("rst_xin", xin, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        job("d_3_4", 3, 4);
        check("d_3_4_const", xin, 32'd25);
        job("d_min_min", -32768, -32768);
        check("d_min_const", xin, 32'h8000_0000);
        job("d_max_m1", 32767, -1);
        check("d_max_const", xin, 32'h3FFF_0002);
        job("d_zero", 0, 0);

        for (int i = 0; i < 20; i++)
            job("rand", int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768);

        // Hold DONE without ack while upstream offers a new pair
        start_job(100, -200);
        wait_done("hold_first", sq_sum(100, -200), 32);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            x_in     = 16'd5;
            y_in     = 16'd12;
            #1;
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("hold_xin", xin, sq_sum(100, -200));
            check("hold_rdy", 32'(data_rdy), 32'd1);
        end
        in_valid = 1'b1;
        out_ack  = 1'b1;
        #1;
        check("ack_accept_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        out_ack  = 1'b0;
        check("ack_accept_rdy", 32'(data_rdy), 32'd0);
        wait_done("b2b_5_12", 32'd169, 32);
        ack();

        // Asynchronous reset in the middle of SQ_Y
        start_job(9, 9);
        repeat (19) tick();
        rstn = 1'b0;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_rdy", 32'(data_rdy), 32'd0);
        check("mid_rst_xin", xin, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("post_rst_rdy", 32'(data_rdy), 32'd0);
        job("post_rst_6_8", 6, 8);

        // Offer during SQ_X must be ignored
        start_job(7, 24);
        repeat (3) tick();
        in_valid = 1'b1;
        x_in     = 16'd1;
        y_in     = 16'd1;
        #1;
        check("busy_in_ready", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        wait_done("busy_7_24", 32'd625, 28);
        ack();
        repeat (40) tick();
        check("busy_no_extra", 32'(data_rdy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
